// File: rtl/alu_cmd_issue.sv
// Command FIFO + single-entry response slot wrapped around a combinational 4-bit ALU.
// Optional saturating capture/overflow counters are enabled by defining ALU_CMD_STATS_EN.
module alu_cmd_issue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_a,
    input  logic [3:0]  cmd_b,
    input  logic [2:0]  cmd_op,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [2:0]  alu_crl,
    input  logic [3:0]  alu_result,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [3:0]  rsp_result,
    output logic [2:0]  rsp_flags,
    output logic [2:0]  rsp_op
`ifdef ALU_CMD_STATS_EN
    ,
    output logic [15:0] stat_ops,
    output logic [15:0] stat_ovf
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        STALL = 2'd2
    } state_t;

    cmd_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q;

    logic             rsp_valid_q, rsp_valid_d;
    logic [3:0]       rsp_result_q, rsp_result_d;
    logic [2:0]       rsp_flags_q, rsp_flags_d;
    logic [2:0]       rsp_op_q, rsp_op_d;

    logic             head_valid;
    logic             slot_free;
    logic             push;
    logic             pop;
    cmd_t             head;

    assign head_valid = (count_q != '0);
    assign cmd_ready  = (count_q != CNT_W'(DEPTH));
    assign push       = cmd_valid & cmd_ready;
    assign slot_free  = !rsp_valid_q | rsp_ready;
    assign pop        = head_valid & slot_free;

    // The ALU is combinational, so the head drives it directly and is captured at the pop edge.
    assign head    = head_valid ? mem_q[rd_ptr_q] : '0;
    assign alu_a   = head.a;
    assign alu_b   = head.b;
    assign alu_crl = head.op;

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_op     = rsp_op_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_op_d     = rsp_op_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (pop) begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = alu_result;
            rsp_flags_d  = {alu_carry, alu_overflow, alu_zero};
            rsp_op_d     = head.op;
        end else if (rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    // NOTE: the payload storage has no reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_a, cmd_b, cmd_op};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_op_q     <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_op_q     <= rsp_op_d;

            // Debug-visible FSM; the datapath is governed by head_valid/slot_free directly.
            unique case (state_q)
                IDLE: begin
                    if (count_d != '0) state_q <= EXEC;
                end
                EXEC: begin
                    if (count_d == '0)                 state_q <= IDLE;
                    else if (head_valid && !slot_free) state_q <= STALL;
                end
                STALL: begin
                    if (rsp_ready) state_q <= EXEC;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ALU_CMD_STATS_EN
    logic [15:0] stat_ops_q;
    logic [15:0] stat_ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_q <= '0;
            stat_ovf_q <= '0;
        end else if (pop) begin
            if (stat_ops_q != 16'hFFFF)                 stat_ops_q <= stat_ops_q + 16'd1;
            if (alu_overflow && stat_ovf_q != 16'hFFFF) stat_ovf_q <= stat_ovf_q + 16'd1;
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_ovf = stat_ovf_q;
`endif

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue: a reference ALU closes the loop on alu_* and responses
// are compared against values derived from the commands that were sent.
module tb_alu_cmd_issue;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_a;
    logic [3:0]  cmd_b;
    logic [2:0]  cmd_op;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [2:0]  alu_crl;
    logic [3:0]  alu_result;
    logic        alu_carry;
    logic        alu_overflow;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_result;
    logic [2:0]  rsp_flags;
    logic [2:0]  rsp_op;
`ifdef ALU_CMD_STATS_EN
    logic [15:0] stat_ops;
    logic [15:0] stat_ovf;
`endif

    int n_cmp;
    int n_fail;

    alu_cmd_issue #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_op       (cmd_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_crl      (alu_crl),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .rsp_op       (rsp_op)
`ifdef ALU_CMD_STATS_EN
        ,
        .stat_ops     (stat_ops),
        .stat_ovf     (stat_ovf)
`endif
    );

    // Reference ALU: returns {result, carry, overflow, zero}; carry/overflow only for add/sub.
    function automatic logic [6:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
        logic [4:0] sum;
        logic [3:0] r;
        logic       c;
        logic       v;
        sum = {1'b0, a} + {1'b0, b};
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            3'd0: begin r = sum[3:0]; c = sum[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
            3'd1: begin r = a - b;    c = sum[4]; v = (a[3] != b[3]) && (r[3] != a[3]); end
            3'd2: r = ~a;
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = {3'b000, ($signed(a) < $signed(b))};
            default: r = {3'b000, (a == b)};
        endcase
        return {r, c, v, (r == 4'd0)};
    endfunction

    assign {alu_result, alu_carry, alu_overflow, alu_zero} = alu_f(alu_a, alu_b, alu_crl);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        tick();
        cmd_valid = 1'b0;
    endtask

    logic [3:0] sa [8];
    logic [3:0] sb [8];
    logic [2:0] so [8];
    logic [3:0] hold_a, hold_b, hold_rr;
    logic [2:0] hold_crl, hold_rf, hold_ro;
    logic       stable;
    logic       any_valid;
    logic       rdy_s;
    int         acc;

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = '0;
        rsp_ready = 1'b1;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_word",  32'({rsp_result, rsp_flags, rsp_op}), 32'd0);
        check("rst_alu",       32'({alu_a, alu_b, alu_crl}), 32'd0);
        check("rst_state",     32'(dut.state_q), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // 1: 3 + 5 = 8, signed overflow
        send(4'd3, 4'd5, 3'd0);
        check("t1_no_bypass", 32'(rsp_valid), 32'd0);
        check("t1_head_alu",  32'({alu_a, alu_b, alu_crl}), 32'({4'd3, 4'd5, 3'd0}));
        tick();
        check("t1_rsp", 32'({rsp_valid, rsp_result, rsp_flags, rsp_op}),
              32'({1'b1, 4'd8, 3'b010, 3'd0}));

        // 2: sub to zero, then equality
        send(4'd7, 4'd7, 3'd1);
        tick();
        check("t2_sub", 32'({rsp_valid, rsp_result, rsp_flags, rsp_op}),
              32'({1'b1, 4'd0, 3'b001, 3'd1}));
        send(4'd9, 4'd9, 3'd7);
        tick();
        check("t2_eq", 32'({rsp_valid, rsp_result, rsp_flags, rsp_op}),
              32'({1'b1, 4'd1, 3'b000, 3'd7}));
        tick();
        check("t2_drained", 32'(rsp_valid), 32'd0);

        // 3: back-pressure fills FIFO plus slot
        sa[0] = 4'd1;  sb[0] = 4'd2;  so[0] = 3'd0;
        sa[1] = 4'd8;  sb[1] = 4'd8;  so[1] = 3'd0;
        sa[2] = 4'd5;  sb[2] = 4'd3;  so[2] = 3'd1;
        sa[3] = 4'd12; sb[3] = 4'd10; so[3] = 3'd3;
        sa[4] = 4'd6;  sb[4] = 4'd9;  so[4] = 3'd5;
        sa[5] = 4'd15; sb[5] = 4'd15; so[5] = 3'd4;
        rsp_ready = 1'b0;
        acc       = 0;
        cmd_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cmd_a = sa[acc];
            cmd_b = sb[acc];
            cmd_op = so[acc];
            rdy_s = cmd_ready;
            tick();
            if (rdy_s && acc < 5) acc++;
        end
        check("t3_accepted",  32'(acc), 32'd5);
        check("t3_cmd_ready", 32'(cmd_ready), 32'd0);
        check("t3_state",     32'(dut.state_q), 32'd2);
        check("t3_rsp0", 32'({rsp_valid, rsp_result, rsp_flags, rsp_op}),
              32'({1'b1, alu_f(sa[0], sb[0], so[0]), so[0]}));
        check("t3_head1", 32'({alu_a, alu_b, alu_crl}), 32'({sa[1], sb[1], so[1]}));
        hold_a = alu_a; hold_b = alu_b; hold_crl = alu_crl;
        hold_rr = rsp_result; hold_rf = rsp_flags; hold_ro = rsp_op;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if ({alu_a, alu_b, alu_crl, rsp_result, rsp_flags, rsp_op, rsp_valid, cmd_ready} !==
                {hold_a, hold_b, hold_crl, hold_rr, hold_rf, hold_ro, 1'b1, 1'b0})
                stable = 1'b0;
        end
        check("t3_stable_10", 32'(stable), 32'd1);
        cmd_valid = 1'b0;

        // 4: release, five responses in order
        rsp_ready = 1'b1;
        tick();
        check("t4_cmd_ready_back", 32'(cmd_ready), 32'd1);
        for (int i = 1; i < 5; i++) begin
            check($sformatf("t4_rsp%0d", i), 32'({rsp_valid, rsp_result, rsp_flags, rsp_op}),
                  32'({1'b1, alu_f(sa[i], sb[i], so[i]), so[i]}));
            tick();
        end
        check("t4_empty", 32'({rsp_valid, dut.state_q}), 32'd0);

        // 5: eight back-to-back commands, pointers wrap twice
        for (int i = 0; i < 8; i++) begin
            sa[i] = 4'(i * 5 + 3);
            sb[i] = 4'(i * 11 + 7);
            so[i] = 3'(i);
        end
        cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cmd_a  = sa[i];
            cmd_b  = sb[i];
            cmd_op = so[i];
            tick();
            if (i > 0)
                check($sformatf("t5_rsp%0d", i - 1),
                      32'({rsp_valid, rsp_result, rsp_flags, rsp_op}),
                      32'({1'b1, alu_f(sa[i-1], sb[i-1], so[i-1]), so[i-1]}));
        end
        cmd_valid = 1'b0;
        tick();
        check("t5_rsp7", 32'({rsp_valid, rsp_result, rsp_flags, rsp_op}),
              32'({1'b1, alu_f(sa[7], sb[7], so[7]), so[7]}));
        tick();

        // 6: asynchronous reset with work queued
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_a  = sa[i];
            cmd_b  = sb[i];
            cmd_op = so[i];
            tick();
        end
        cmd_valid = 1'b0;
        check("t6_pre_full_slot", 32'({rsp_valid, cmd_ready}), 32'({1'b1, 1'b1}));
        rst_n = 1'b0;
        #1;
        check("t6_rst_now", 32'({rsp_valid, cmd_ready, alu_a, alu_b, alu_crl}),
              32'({1'b0, 1'b1, 11'd0}));
`ifdef ALU_CMD_STATS_EN
        check("t6_stats", 32'({stat_ops, stat_ovf}), 32'd0);
`endif
        #3 rst_n = 1'b1;
        rsp_ready = 1'b1;
        any_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (rsp_valid !== 1'b0) any_valid = 1'b1;
        end
        check("t6_no_stale", 32'(any_valid), 32'd0);
        check("t6_idle", 32'({dut.state_q, cmd_ready}), 32'({2'd0, 1'b1}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
